audio_out_sequencer: RTL and testbench

Drains the left and right audio output FIFOs of fm_radio_top in lockstep, one stereo frame per pacing period. Each frame goes out as an interleaved L-then-R stream on a single valid/ready port toward the DAC/serializer. Both channels are always popped in the same cycle, so the streams cannot drift out of alignment. Missed frame slots are counted for debug.

---
 rtl/audio_out_sequencer.sv | 146 ++++++++++++++
 tb/tb_audio_out_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_sequencer.sv
// Audio output sequencer: pops the left and right audio FIFOs together once per
// frame slot and streams the pair out as L then R on one valid/ready port.
// Ports: clock/reset (async active-low); enable gates frame-slot ticks;
//   left_*/right_* FWFT FIFO read side; out_valid/out_ready/out_data/out_chan
//   sample stream (chan 0 = left, 1 = right); busy = FSM not idle;
//   underrun_count = saturating count of frame slots that produced no frame.
module audio_out_sequencer #(
  parameter int DATA_SIZE    = 32,
  parameter int FRAME_PERIOD = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 left_empty,
  input  logic [DATA_SIZE-1:0] left_dout,
  output logic                 left_rd_en,
  input  logic                 right_empty,
  input  logic [DATA_SIZE-1:0] right_dout,
  output logic                 right_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_chan,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] underrun_count
);

  localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND_L = 2'd2,
    SEND_R = 2'd3
  } state_t;

  state_t               state, next_state;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 frame_due;
  logic                 consume;
  logic                 empty_miss;
  logic                 tick_drop;
  logic                 underrun_inc;
  logic [DATA_SIZE-1:0] l_hold, r_hold;

  // Frame-slot pacing: one tick every FRAME_PERIOD cycles while enabled.
  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A tick landing on an unconsumed frame_due is a lost slot. A tick in the
  // same cycle as a consume re-arms the flag (consume first, then set).
  assign tick_drop    = tick && frame_due && !consume;
  assign underrun_inc = tick_drop || empty_miss;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_due <= 1'b0;
    end else if (!enable) begin
      frame_due <= 1'b0;
    end else if (tick) begin
      frame_due <= 1'b1;
    end else if (consume) begin
      frame_due <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_count <= '0;
    end else if (underrun_inc && (underrun_count != {CNT_WIDTH{1'b1}})) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    consume    = 1'b0;
    empty_miss = 1'b0;
    case (state)
      IDLE: begin
        if (frame_due) begin
          consume = 1'b1;
          // Never pop one channel alone; a slot with either side empty is lost.
          if (!left_empty && !right_empty) begin
            next_state = FETCH;
          end else begin
            empty_miss = 1'b1;
          end
        end
      end
      FETCH:  next_state = SEND_L;
      SEND_L: if (out_ready) next_state = SEND_R;
      SEND_R: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FWFT heads are valid during FETCH; capture them as the pops take effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l_hold <= '0;
      r_hold <= '0;
    end else if (state == FETCH) begin
      l_hold <= left_dout;
      r_hold <= right_dout;
    end
  end

  // Read enables come from the registered state only, so empty flags never
  // reach the pop strobes combinationally.
  assign left_rd_en  = (state == FETCH);
  assign right_rd_en = (state == FETCH);
  assign out_valid   = (state == SEND_L) || (state == SEND_R);
  assign out_chan    = (state == SEND_R);
  assign busy        = (state != IDLE);

  always_comb begin
    out_data = '0;
    if (state == SEND_L) begin
      out_data = l_hold;
    end else if (state == SEND_R) begin
      out_data = r_hold;
    end
  end

endmodule

// File: tb/tb_audio_out_sequencer.sv
// Directed bench for audio_out_sequencer with behavioural FWFT FIFOs.
// Ports: none (top-level bench).
module tb_audio_out_sequencer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          left_empty, right_empty;
  logic [DW-1:0] left_dout, right_dout;
  logic          left_rd_en, right_rd_en;
  logic          out_valid, out_ready, out_chan, busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] underrun_count;

  audio_out_sequencer #(
    .DATA_SIZE(DW), .FRAME_PERIOD(16), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left_empty(left_empty), .left_dout(left_dout), .left_rd_en(left_rd_en),
    .right_empty(right_empty), .right_dout(right_dout), .right_rd_en(right_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy), .underrun_count(underrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural FWFT FIFOs: pushed by the stimulus, popped by the monitor.
  logic [DW-1:0] lmem [16];
  logic [DW-1:0] rmem [16];
  int lhead = 0, ltail = 0, rhead = 0, rtail = 0;
  assign left_empty  = (lhead == ltail);
  assign right_empty = (rhead == rtail);
  assign left_dout   = lmem[lhead % 16];
  assign right_dout  = rmem[rhead % 16];

  // Event log: accepted samples and pop cycles, stamped with the cycle index.
  int            cyc = 0;
  int            o_n = 0, r_n = 0, rd_mismatch = 0;
  logic [DW-1:0] o_data [64];
  logic          o_chan [64];
  int            o_cyc  [64];
  int            r_cyc  [64];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      o_data[o_n % 64] <= out_data;
      o_chan[o_n % 64] <= out_chan;
      o_cyc[o_n % 64]  <= cyc;
      o_n <= o_n + 1;
    end
    if (left_rd_en) begin
      r_cyc[r_n % 64] <= cyc;
      r_n <= r_n + 1;
    end
    if (left_rd_en != right_rd_en) rd_mismatch <= rd_mismatch + 1;
    if (left_rd_en && !left_empty) lhead <= lhead + 1;
    if (right_rd_en && !right_empty) rhead <= rhead + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_l(input logic [DW-1:0] v);
    lmem[ltail % 16] = v;
    ltail = ltail + 1;
  endtask

  task automatic push_r(input logic [DW-1:0] v);
    rmem[rtail % 16] = v;
    rtail = rtail + 1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] exp_d [6];
  int c0, c1, ob, rb;

  initial begin
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1;
    step(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rd_l", 32'(left_rd_en), 0);
    chk("rst_rd_r", 32'(right_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_underrun", 32'(underrun_count), 0);
    reset = 1'b1;
    step(2);

    // Steady stream: three frames, 16 cycles apart.
    exp_d[0] = 32'h400; exp_d[1] = 32'h1; exp_d[2] = 32'h800;
    exp_d[3] = 32'h2;   exp_d[4] = 32'hC00; exp_d[5] = 32'h3;
    push_l(32'h400); push_l(32'h800); push_l(32'hC00);
    push_r(32'h1);   push_r(32'h2);   push_r(32'h3);
    ob = o_n; rb = r_n;
    enable = 1'b1; c0 = cyc;
    step(55);
    enable = 1'b0;
    step(5);
    chk("stream_count", 32'(o_n - ob), 6);
    chk("stream_rd_count", 32'(r_n - rb), 3);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_chan%0d", i), 32'(o_chan[ob + i]), 32'(i % 2));
      chk($sformatf("stream_data%0d", i), o_data[ob + i], exp_d[i]);
      chk($sformatf("stream_cyc%0d", i), 32'(o_cyc[ob + i] - c0), 32'(18 + 16 * (i / 2) + (i % 2)));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("stream_rd_cyc%0d", i), 32'(r_cyc[rb + i] - c0), 32'(17 + 16 * i));
    chk("stream_underrun", 32'(underrun_count), 0);

    // Backpressure: 40-cycle stall from the first SEND_L.
    pulse_reset();
    push_l(32'h111); push_l(32'h222);
    push_r(32'h333); push_r(32'h444);
    ob = o_n;
    enable = 1'b1; c0 = cyc;
    step(18);
    out_ready = 1'b0;
    step(20);
    chk("bp_valid_mid", 32'(out_valid), 1);
    chk("bp_data_mid", out_data, 32'h111);
    chk("bp_chan_mid", 32'(out_chan), 0);
    chk("bp_underrun_mid", 32'(underrun_count), 0);
    step(20);
    chk("bp_data_end", out_data, 32'h111);
    chk("bp_underrun_end", 32'(underrun_count), 1);
    out_ready = 1'b1;
    step(3);
    enable = 1'b0;
    step(10);
    chk("bp_count", 32'(o_n - ob), 4);
    chk("bp_d0", o_data[ob + 0], 32'h111);
    chk("bp_d1", o_data[ob + 1], 32'h333);
    chk("bp_d2", o_data[ob + 2], 32'h222);
    chk("bp_d3", o_data[ob + 3], 32'h444);
    chk("bp_c0", 32'(o_cyc[ob + 0] - c0), 58);
    chk("bp_c1", 32'(o_cyc[ob + 1] - c0), 59);
    chk("bp_c2", 32'(o_cyc[ob + 2] - c0), 62);
    chk("bp_c3", 32'(o_cyc[ob + 3] - c0), 63);
    chk("bp_underrun_final", 32'(underrun_count), 1);

    // Single empty side: slot lost, left sample untouched.
    pulse_reset();
    push_l(32'h400);
    ob = o_n; rb = r_n;
    enable = 1'b1; c0 = cyc;
    step(20);
    chk("se_rd_count", 32'(r_n - rb), 0);
    chk("se_underrun", 32'(underrun_count), 1);
    chk("se_left_nonempty", 32'(left_empty), 0);
    chk("se_left_head", left_dout, 32'h400);
    push_r(32'h5);
    step(20);
    enable = 1'b0;
    step(5);
    chk("se_count", 32'(o_n - ob), 2);
    chk("se_d0", o_data[ob + 0], 32'h400);
    chk("se_d1", o_data[ob + 1], 32'h5);
    chk("se_c0", 32'(o_cyc[ob + 0] - c0), 34);
    chk("se_underrun_final", 32'(underrun_count), 1);

    // Enable drop during SEND_L: frame completes, then silence, then restart.
    pulse_reset();
    push_l(32'h7); push_r(32'h8);
    ob = o_n; rb = r_n;
    enable = 1'b1; c0 = cyc;
    step(18);
    out_ready = 1'b0; enable = 1'b0;
    chk("ed_in_send_l", 32'(out_valid && !out_chan), 1);
    step(2);
    out_ready = 1'b1;
    step(100);
    chk("ed_rd_quiet", 32'(r_n - rb), 1);
    chk("ed_out_count", 32'(o_n - ob), 2);
    chk("ed_r_data", o_data[ob + 1], 32'h8);
    chk("ed_r_chan", 32'(o_chan[ob + 1]), 1);
    push_l(32'h9); push_r(32'hA);
    enable = 1'b1; c1 = cyc;
    step(25);
    enable = 1'b0;
    step(3);
    chk("ed_rd_count", 32'(r_n - rb), 2);
    chk("ed_rd_restart", 32'(r_cyc[rb + 1] - c1), 17);
    chk("ed_d2", o_data[ob + 2], 32'h9);
    chk("ed_d3", o_data[ob + 3], 32'hA);

    // Saturation: empty FIFOs for 20+ slots with a 4-bit counter.
    pulse_reset();
    chk("sat_fifos_empty", 32'(left_empty && right_empty), 1);
    rb = r_n;
    enable = 1'b1;
    step(170);
    chk("sat_ten", 32'(underrun_count), 10);
    step(170);
    chk("sat_max", 32'(underrun_count), 15);
    step(100);
    chk("sat_hold", 32'(underrun_count), 15);
    chk("sat_no_rd", 32'(r_n - rb), 0);
    enable = 1'b0;

    // Async reset while stalled in SEND_R.
    pulse_reset();
    push_l(32'h1); push_r(32'h2);
    ob = o_n;
    enable = 1'b1;
    step(19);
    out_ready = 1'b0;
    step(2);
    chk("ar_pre_valid", 32'(out_valid), 1);
    chk("ar_pre_chan", 32'(out_chan), 1);
    chk("ar_pre_data", out_data, 32'h2);
    #2;
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_rd_l", 32'(left_rd_en), 0);
    chk("ar_rd_r", 32'(right_rd_en), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_underrun", 32'(underrun_count), 0);
    chk("ar_data", out_data, 0);
    step(3);
    enable = 1'b0;
    reset = 1'b1;
    step(3);
    chk("ar_no_handshake", 32'(o_n - ob), 1);
    chk("ar_idle", 32'(busy), 0);

    chk("rd_pairing", 32'(rd_mismatch), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
